dp_accum_unit: RTL and testbench

// - N-lane signed dot-product engine with per-lane operand latches, registered multipliers,

---
 rtl/dp_pkg.sv | 45 ++++
 rtl/dp_adder_tree.sv | 47 ++++
 rtl/dp_accum_unit.sv | 156 +++++++++++++++
 tb/tb_dp_accum_unit.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// ---------------------------------------------------------------------------
// dp_pkg
// Shared helpers for the dot-product accumulator slice:
//   clog2      - ceiling log2, usable in parameter/localparam expressions
//   dw_prod    - full-precision product width for a given operand width
//   dw_sum     - exact adder-tree output width for N products
//   sat_clamp  - clamp a 64-bit signed value into a signed 'width'-bit range
// ---------------------------------------------------------------------------
package dp_pkg;

   localparam int SAT_W = 64;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int dw_prod(input int dw_data);
      return 2 * dw_data;
   endfunction

   function automatic int dw_sum(input int dw_data, input int n_lane);
      return dw_prod(dw_data) + clog2(n_lane);
   endfunction

   // The caller sign-extends into 64 bits, so any width up to 63 fits with
   // one bit of headroom for the pre-clamp sum.
   function automatic logic signed [SAT_W-1:0] sat_clamp(
      input logic signed [SAT_W-1:0] value,
      input int                      width
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)      return hi;
      else if (value < lo) return lo;
      else                 return value;
   endfunction

endpackage

// File: rtl/dp_adder_tree.sv
// ---------------------------------------------------------------------------
// dp_adder_tree
// Combinational balanced signed adder tree. Each level sign-extends its two
// halves by one bit before adding, so the result is exact.
// Ports:
//   in_data  in   N_IN*DW_IN           packed signed inputs, item k at [k*DW_IN +: DW_IN]
//   out_sum  out  DW_IN+clog2(N_IN)    signed sum of all items
// N_IN must be a power of two; N_IN == 1 is a plain pass-through.
// ---------------------------------------------------------------------------
module dp_adder_tree
   import dp_pkg::*;
#(
   parameter int DW_IN = 16,
   parameter int N_IN  = 4
) (
   input  logic [N_IN*DW_IN-1:0]                in_data,
   output logic signed [DW_IN+clog2(N_IN)-1:0]  out_sum
);

   localparam int DW_OUT = DW_IN + clog2(N_IN);

   generate
      if (N_IN == 1) begin : g_leaf
         assign out_sum = in_data;
      end else begin : g_split
         localparam int N_HALF  = N_IN / 2;
         localparam int DW_HALF = DW_IN + clog2(N_HALF);

         logic signed [DW_HALF-1:0] sum_lo;
         logic signed [DW_HALF-1:0] sum_hi;

         dp_adder_tree #(.DW_IN(DW_IN), .N_IN(N_HALF)) u_lo (
            .in_data (in_data[N_HALF*DW_IN-1:0]),
            .out_sum (sum_lo)
         );

         dp_adder_tree #(.DW_IN(DW_IN), .N_IN(N_HALF)) u_hi (
            .in_data (in_data[N_IN*DW_IN-1:N_HALF*DW_IN]),
            .out_sum (sum_hi)
         );

         // Signed size casts sign-extend each half by one bit.
         assign out_sum = DW_OUT'(sum_lo) + DW_OUT'(sum_hi);
      end
   endgenerate

endmodule

// File: rtl/dp_accum_unit.sv
// ---------------------------------------------------------------------------
// dp_accum_unit
// N-lane signed dot-product engine: per-lane operand latches, registered
// full-precision multipliers (S1), registered adder tree (S2) and a
// saturating accumulator (S3). Latency from in_issue to out_valid is 3
// enabled cycles; one issue per enabled cycle is sustained.
// Ports:
//   clk, reset      clock (rising edge), synchronous active-high reset
//   enable          0 freezes every register (full stall)
//   in_a, in_b      lane k operand at [k*DW_DATA +: DW_DATA], signed
//   in_vld_a/b      per-lane load strobes for the A/B latches
//   in_issue        launch one dot product from the current latch contents
//   in_acc_clr      with in_issue: the result replaces the accumulator
//   out_data        accumulator value, signed
//   out_valid       out_data was updated by a result this cycle
//   out_ovf         that result saturated; meaningful with out_valid
//
// Handshake: valid-only, no backpressure. in_issue is accepted on every
// enabled cycle it is high; out_valid is high for exactly one enabled cycle
// per accepted issue and simply holds while enable is low, so a stall never
// drops or duplicates a result. The only way to throttle is enable.
// ---------------------------------------------------------------------------
module dp_accum_unit
   import dp_pkg::*;
#(
   parameter int DW_DATA = 8,
   parameter int N_LANE  = 4,
   parameter int DW_ACC  = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [N_LANE*DW_DATA-1:0]   in_a,
   input  logic [N_LANE*DW_DATA-1:0]   in_b,
   input  logic [N_LANE-1:0]           in_vld_a,
   input  logic [N_LANE-1:0]           in_vld_b,
   input  logic                        in_issue,
   input  logic                        in_acc_clr,
   output logic signed [DW_ACC-1:0]    out_data,
   output logic                        out_valid,
   output logic                        out_ovf
);

   localparam int DW_PROD = dw_prod(DW_DATA);
   localparam int DW_SUM  = dw_sum(DW_DATA, N_LANE);

   generate
      if (DW_ACC < DW_SUM) begin : g_bad_acc_narrow
         $error("dp_accum_unit: DW_ACC (%0d) must be >= DW_SUM (%0d)", DW_ACC, DW_SUM);
      end
      if (DW_ACC > SAT_W - 1) begin : g_bad_acc_wide
         $error("dp_accum_unit: DW_ACC (%0d) must be <= %0d", DW_ACC, SAT_W - 1);
      end
      if ((N_LANE < 1) || ((N_LANE & (N_LANE - 1)) != 0)) begin : g_bad_lanes
         $error("dp_accum_unit: N_LANE (%0d) must be a power of two", N_LANE);
      end
   endgenerate

   // S0: operand latches
   logic signed [DW_DATA-1:0] a_lat [N_LANE];
   logic signed [DW_DATA-1:0] b_lat [N_LANE];

   // S1: products and issue tracking
   logic [N_LANE*DW_PROD-1:0] prod_q;
   logic                      v1_q;
   logic                      clr1_q;

   // S2: reduced sum and issue tracking
   logic signed [DW_SUM-1:0]  tree_sum;
   logic signed [DW_SUM-1:0]  sum_q;
   logic                      v2_q;
   logic                      clr2_q;

   // S3: accumulator
   logic signed [DW_ACC-1:0]  acc_q;
   logic signed [SAT_W-1:0]   base_ext;
   logic signed [SAT_W-1:0]   sum_ext;
   logic signed [SAT_W-1:0]   total;
   logic signed [SAT_W-1:0]   clamped;

   // Latches load on their strobes only. The S1 multipliers read the latch
   // registers, so a same-cycle load is seen by the next issue, not this one.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_LANE; k++) begin
            a_lat[k] <= '0;
            b_lat[k] <= '0;
         end
      end else if (enable) begin
         for (int k = 0; k < N_LANE; k++) begin
            if (in_vld_a[k]) a_lat[k] <= in_a[k*DW_DATA +: DW_DATA];
            if (in_vld_b[k]) b_lat[k] <= in_b[k*DW_DATA +: DW_DATA];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         v1_q   <= 1'b0;
         clr1_q <= 1'b0;
      end else if (enable) begin
         for (int k = 0; k < N_LANE; k++) begin
            prod_q[k*DW_PROD +: DW_PROD] <= DW_PROD'(a_lat[k]) * DW_PROD'(b_lat[k]);
         end
         v1_q   <= in_issue;
         clr1_q <= in_issue & in_acc_clr;
      end
   end

   dp_adder_tree #(.DW_IN(DW_PROD), .N_IN(N_LANE)) u_tree (
      .in_data (prod_q),
      .out_sum (tree_sum)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q  <= '0;
         v2_q   <= 1'b0;
         clr2_q <= 1'b0;
      end else if (enable) begin
         sum_q  <= tree_sum;
         v2_q   <= v1_q;
         clr2_q <= clr1_q;
      end
   end

   // Add in 64 bits (wider than DW_ACC+1, so the raw sum is exact), then
   // clamp. Overflow is simply "the clamp changed the value".
   always_comb begin
      base_ext = clr2_q ? '0 : SAT_W'(acc_q);
      sum_ext  = SAT_W'(sum_q);
      total    = base_ext + sum_ext;
      clamped  = sat_clamp(total, DW_ACC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         out_valid <= 1'b0;
         out_ovf   <= 1'b0;
      end else if (enable) begin
         if (v2_q) begin
            acc_q     <= clamped[DW_ACC-1:0];
            out_valid <= 1'b1;
            out_ovf   <= (total != clamped);
         end else begin
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
         end
      end
   end

   assign out_data = acc_q;

endmodule

// File: tb/tb_dp_accum_unit.sv
// ---------------------------------------------------------------------------
// tb_dp_accum_unit
// Two instances share control: u_dut (4 lanes, 32-bit acc) and u_sat
// (1 lane, 16-bit acc) for saturation. The reference model keeps lane
// values as ints, computes each dot product when issued, and retires it
// two enabled edges later into a longint accumulator with plain clamping.
// ---------------------------------------------------------------------------
module tb_dp_accum_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, enable, in_issue, in_acc_clr;
   logic [31:0] a0, b0;
   logic [3:0]  va0, vb0;
   logic [7:0]  a1, b1;
   logic [0:0]  va1, vb1;

   logic signed [31:0] out_data0;
   logic               out_valid0, out_ovf0;
   logic signed [15:0] out_data1;
   logic               out_valid1, out_ovf1;

   logic [33:0] obs_w0;
   logic [17:0] obs_w1;
   assign obs_w0 = {out_valid0, out_ovf0, out_data0};
   assign obs_w1 = {out_valid1, out_ovf1, out_data1};

   int n_checks = 0;
   int n_errors = 0;

   dp_accum_unit #(.DW_DATA(8), .N_LANE(4), .DW_ACC(32)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_a       (a0),
      .in_b       (b0),
      .in_vld_a   (va0),
      .in_vld_b   (vb0),
      .in_issue   (in_issue),
      .in_acc_clr (in_acc_clr),
      .out_data   (out_data0),
      .out_valid  (out_valid0),
      .out_ovf    (out_ovf0)
   );

   dp_accum_unit #(.DW_DATA(8), .N_LANE(1), .DW_ACC(16)) u_sat (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_a       (a1),
      .in_b       (b1),
      .in_vld_a   (va1),
      .in_vld_b   (vb1),
      .in_issue   (in_issue),
      .in_acc_clr (in_acc_clr),
      .out_data   (out_data1),
      .out_valid  (out_valid1),
      .out_ovf    (out_ovf1)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int     inst;
      longint dot;
      bit     clr;
      int     due;
   } pend_t;

   pend_t       exp_q[$];
   int          lat_a [2][4];
   int          lat_b [2][4];
   longint      acc_m [2];
   bit          exp_v [2];
   bit          exp_o [2];
   int          en_cnt = 0;
   logic [33:0] exp_w0;
   logic [17:0] exp_w1;

   task automatic retire(input pend_t p);
      longint lim, t, c;
      lim = (p.inst == 0) ? (64'sd1 <<< 31) : (64'sd1 <<< 15);
      t   = (p.clr ? 64'sd0 : acc_m[p.inst]) + p.dot;
      if (t > lim - 1)   c = lim - 1;
      else if (t < -lim) c = -lim;
      else               c = t;
      exp_o[p.inst] = (c != t);
      exp_v[p.inst] = 1'b1;
      acc_m[p.inst] = c;
   endtask

   // One clock: model reacts to the inputs present at the rising edge,
   // then we return at the falling edge where outputs are sampled.
   task automatic tick();
      pend_t p;
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
               lat_a[i][k] = 0;
               lat_b[i][k] = 0;
            end
            acc_m[i] = 0;
            exp_v[i] = 1'b0;
            exp_o[i] = 1'b0;
         end
         exp_q.delete();
      end else if (enable) begin
         en_cnt++;
         for (int i = 0; i < 2; i++) begin
            exp_v[i] = 1'b0;
            exp_o[i] = 1'b0;
         end
         while (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
            p = exp_q.pop_front();
            retire(p);
         end
         if (in_issue) begin
            for (int i = 0; i < 2; i++) begin
               p.inst = i;
               p.dot  = 0;
               for (int k = 0; k < ((i == 0) ? 4 : 1); k++) begin
                  p.dot += longint'(lat_a[i][k]) * longint'(lat_b[i][k]);
               end
               p.clr = in_acc_clr;
               p.due = en_cnt + 2;
               exp_q.push_back(p);
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (va0[k]) lat_a[0][k] = int'($signed(a0[k*8 +: 8]));
            if (vb0[k]) lat_b[0][k] = int'($signed(b0[k*8 +: 8]));
         end
         if (va1[0]) lat_a[1][0] = int'($signed(a1));
         if (vb1[0]) lat_b[1][0] = int'($signed(b1));
      end
      exp_w0 = {exp_v[0], exp_o[0], acc_m[0][31:0]};
      exp_w1 = {exp_v[1], exp_o[1], acc_m[1][15:0]};
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      enable     = 1'b1;
      in_issue   = 1'b0;
      in_acc_clr = 1'b0;
      va0 = '0; vb0 = '0; va1 = '0; vb1 = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b1;
      in_issue = 1'b1;
      in_acc_clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a0 = $urandom(); b0 = $urandom(); va0 = 4'hF; vb0 = 4'hF;
         a1 = 8'($urandom()); b1 = 8'($urandom()); va1 = 1'b1; vb1 = 1'b1;
         tick();
         n_checks++;
         if (obs_w0 !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_w4 cyc%0d: got %h want 0", i, obs_w0);
         end
         n_checks++;
         if (obs_w1 !== 18'd0) begin
            n_errors++;
            $display("FAIL reset_w1 cyc%0d: got %h want 0", i, obs_w1);
         end
      end
      reset = 1'b0;
      idle_inputs();
      in_issue = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         in_issue = 1'b0;
         n_checks++;
         if (obs_w0 !== exp_w0) begin
            n_errors++;
            $display("FAIL zero_issue cyc%0d: got %h want %h", i, obs_w0, exp_w0);
         end
      end
      n_checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'sd0 || out_ovf0 !== 1'b0) begin
         n_errors++;
         $display("FAIL zero_issue_latency: got v=%b d=%0d o=%b want v=1 d=0 o=0",
                  out_valid0, out_data0, out_ovf0);
      end
   endtask

   task automatic test_dot();
      idle_inputs();
      a0 = {8'd4, 8'd3, 8'd2, 8'd1};
      b0 = {8'd8, 8'd7, 8'd6, 8'd5};
      va0 = 4'hF; vb0 = 4'hF;
      tick();
      for (int r = 0; r < 2; r++) begin
         idle_inputs();
         in_issue = 1'b1;
         in_acc_clr = (r == 0);
         for (int i = 0; i < 3; i++) begin
            tick();
            idle_inputs();
            n_checks++;
            if (obs_w0 !== exp_w0) begin
               n_errors++;
               $display("FAIL dot r%0d cyc%0d: got %h want %h", r, i, obs_w0, exp_w0);
            end
         end
         n_checks++;
         if (out_valid0 !== 1'b1 || out_data0 !== ((r == 0) ? 32'sd70 : 32'sd140)) begin
            n_errors++;
            $display("FAIL dot_value r%0d: got v=%b d=%0d want v=1 d=%0d",
                     r, out_valid0, out_data0, (r == 0) ? 70 : 140);
         end
      end
   endtask

   task automatic test_no_bypass();
      idle_inputs();
      a0 = {4{8'h80}}; b0 = {4{8'h80}};
      va0 = 4'hF; vb0 = 4'hF;
      in_issue = 1'b1;
      tick();
      idle_inputs();
      in_issue = 1'b1;
      tick();
      idle_inputs();
      tick();
      n_checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'sd210) begin
         n_errors++;
         $display("FAIL no_bypass_old: got v=%b d=%0d want v=1 d=210", out_valid0, out_data0);
      end
      tick();
      n_checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'sd65746 || obs_w0 !== exp_w0) begin
         n_errors++;
         $display("FAIL no_bypass_new: got %h d=%0d want d=65746 model %h", obs_w0, out_data0, exp_w0);
      end
      tick();
   endtask

   task automatic test_saturation();
      idle_inputs();
      a1 = 8'd127; b1 = 8'd127; va1 = 1'b1; vb1 = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         idle_inputs();
         in_issue = (i < 4);
         in_acc_clr = (i == 0);
         tick();
         n_checks++;
         if (obs_w1 !== exp_w1) begin
            n_errors++;
            $display("FAIL sat_hi cyc%0d: got %h want %h", i, obs_w1, exp_w1);
         end
      end
      n_checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== 16'sh7FFF || out_ovf1 !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_hi_clamp: got v=%b d=%0d o=%b want v=1 d=32767 o=1",
                  out_valid1, out_data1, out_ovf1);
      end
      idle_inputs();
      a1 = 8'h80; va1 = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         idle_inputs();
         in_issue = (i < 6);
         tick();
         n_checks++;
         if (obs_w1 !== exp_w1) begin
            n_errors++;
            $display("FAIL sat_lo cyc%0d: got %h want %h", i, obs_w1, exp_w1);
         end
      end
      n_checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== -16'sd32768 || out_ovf1 !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_lo_clamp: got v=%b d=%0d o=%b want v=1 d=-32768 o=1",
                  out_valid1, out_data1, out_ovf1);
      end
   endtask

   task automatic test_stall();
      int pulses;
      int first_at;
      idle_inputs();
      for (int i = 0; i < 3; i++) tick();
      in_issue = 1'b1;
      tick();
      idle_inputs();
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a0 = $urandom(); va0 = 4'hF;
         in_issue = 1'b1;
         tick();
         n_checks++;
         if (out_valid0 !== 1'b0 || obs_w0 !== exp_w0) begin
            n_errors++;
            $display("FAIL stall_quiet cyc%0d: got %h want %h", i, obs_w0, exp_w0);
         end
      end
      idle_inputs();
      pulses = 0;
      first_at = -1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid0 === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = i;
         end
      end
      n_checks++;
      if (pulses != 1 || first_at != 1) begin
         n_errors++;
         $display("FAIL stall_pulse: got pulses=%0d at=%0d want pulses=1 at=1", pulses, first_at);
      end
      // A pulse that is high when the stall starts holds, then drops once.
      in_issue = 1'b1;
      tick();
      idle_inputs();
      tick();
      tick();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (out_valid0 !== 1'b1 || obs_w0 !== exp_w0) begin
            n_errors++;
            $display("FAIL stall_hold cyc%0d: got %h want %h", i, obs_w0, exp_w0);
         end
      end
      enable = 1'b1;
      tick();
      n_checks++;
      if (out_valid0 !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_release: got v=%b want v=0", out_valid0);
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      in_issue = 1'b1;
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (out_valid0 !== 1'b0 || out_data0 !== 32'sd0 || out_valid1 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid cyc%0d: got v=%b d=%0d v1=%b want v=0 d=0 v1=0",
                     i, out_valid0, out_data0, out_valid1);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 11; i++) begin
         idle_inputs();
         in_issue = (i < 8);
         in_acc_clr = (i == 0);
         a0 = $urandom(); b0 = $urandom();
         va0 = 4'($urandom()); vb0 = 4'($urandom());
         a1 = 8'($urandom()); va1 = 1'($urandom());
         tick();
         n_checks++;
         if (obs_w0 !== exp_w0) begin
            n_errors++;
            $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs_w0, exp_w0);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         reset      = ($urandom_range(0, 49) == 0);
         enable     = ($urandom_range(0, 99) < 85);
         in_issue   = 1'($urandom());
         in_acc_clr = ($urandom_range(0, 7) == 0);
         a0 = $urandom(); b0 = $urandom();
         va0 = 4'($urandom()); vb0 = 4'($urandom());
         a1 = 8'($urandom()); b1 = 8'($urandom());
         va1 = 1'($urandom()); vb1 = 1'($urandom());
         tick();
         n_checks++;
         if (obs_w0 !== exp_w0) begin
            n_errors++;
            $display("FAIL random_w4 cyc%0d: got %h want %h", i, obs_w0, exp_w0);
         end
         n_checks++;
         if (obs_w1 !== exp_w1) begin
            n_errors++;
            $display("FAIL random_w1 cyc%0d: got %h want %h", i, obs_w1, exp_w1);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      test_reset();
      test_dot();
      test_no_bypass();
      test_saturation();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
